// File: rtl/input_word_packer.sv
// Packs a stream of 64-bit words into one 1024-bit Skein input block and hands it downstream.
// Optional build macro INPUT_WORD_PACKER_ZERO_PAD_EN: word_last_i closes a short, zero-padded block.
module input_word_packer #(
    parameter int WORD_W    = 64,
    parameter int NUM_WORDS = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        word_valid_i,
    output logic                        word_ready_o,
    input  logic [WORD_W-1:0]           word_data_i,
    input  logic                        word_last_i,
    output logic [WORD_W*NUM_WORDS-1:0] block_o,
    output logic                        block_valid_o,
    input  logic                        block_ready_i,
    output logic [4:0]                  block_words_o
);

    localparam int                IDX_W    = $clog2(NUM_WORDS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic {
        FILL,
        HOLD
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic             word_accept;
    logic             block_take;
    logic             block_done;

`ifdef INPUT_WORD_PACKER_ZERO_PAD_EN
    assign block_done = (idx == LAST_IDX) || word_last_i;
`else
    logic unused_word_last;
    assign unused_word_last = word_last_i;
    assign block_done       = (idx == LAST_IDX);
`endif

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next    = state;
        word_ready_o  = (state == FILL);
        block_valid_o = (state == HOLD);
        word_accept   = word_valid_i & word_ready_o;
        block_take    = block_valid_o & block_ready_i;

        case (state)
            FILL: if (word_accept && block_done) state_next = HOLD;
            HOLD: if (block_take) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values, independent of statement order.
    // NOTE: the block register is reset explicitly because zero padding relies on unwritten slots reading 0.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state         <= FILL;
            block_o       <= '0;
            block_words_o <= 5'd0;
            idx           <= '0;
        end else begin
            state <= state_next;
            if (word_accept) begin
                block_o[int'(idx)*WORD_W +: WORD_W] <= word_data_i;
                block_words_o                       <= block_words_o + 5'd1;
                // Saturate at the last slot; the handshake rewinds to 0.
                if (idx != LAST_IDX) idx <= idx + 1'b1;
            end
            if (block_take) begin
                block_o       <= '0;
                block_words_o <= 5'd0;
                idx           <= '0;
            end
        end
    end

endmodule

// File: doc/input_word_packer.md
Name: input_word_packer

Overview:
- Writer-side counterpart of the per-word input register select: accepts a stream of 64-bit words over a valid/ready handshake and packs them into a 1024-bit Skein input block.
- Word k is placed at bits [64k+63:64k].
- Presents the completed block to the downstream core over a second valid/ready handshake, then clears itself for the next block.

Parameters:
- WORD_W, 64, width of one input word in bits.
- NUM_WORDS, 16, words per block. Block width = WORD_W*NUM_WORDS = 1024.

Ports:
- clk_i  input  1  system clock; all logic on the rising edge.
- rst_n_i  input  1  synchronous active-low reset.
- word_valid_i  input  1  upstream word available.
- word_ready_o  output  1  packer can accept a word this cycle.
- word_data_i  input  WORD_W  word payload.
- word_last_i  input  1  final word of a short message. Used only with ZERO_PAD_EN.
- block_o  output  WORD_W*NUM_WORDS  packed block; word k at [64k+63:64k].
- block_valid_o  output  1  block_o complete and stable.
- block_ready_i  input  1  downstream consumes block.
- block_words_o  output  5  number of words written into the current block (0..16).

Behaviour:
- Reset (rst_n_i=0 at a clock edge): state=FILL, block_o=0, block_valid_o=0, word_ready_o=1, block_words_o=0, write index=0.
- Reset overrides everything, including a partially filled block and a pending block_valid_o; the contents are discarded.
- Registered state machine with two states, FILL and HOLD.
- FILL:
  - word_ready_o=1, block_valid_o=0.
  - Word accept = word_valid_i & word_ready_o. On accept:
    - Slot[idx] <= word_data_i.
    - block_words_o <= block_words_o+1.
    - idx <= idx+1.
  - If the accepted word is at idx==NUM_WORDS-1, the next state is HOLD. No wrap-around write occurs; idx is never incremented past 15.
  - word_valid_i=0: nothing changes.
- HOLD:
  - word_ready_o=0, block_valid_o=1.
  - block_o and block_words_o stay stable until the handshake.
  - Handshake = block_valid_o & block_ready_i. On handshake:
    - Next state is FILL.
    - block_o <= 0, block_words_o <= 0, idx <= 0.
  - block_ready_i=0: state holds indefinitely; block_valid_o stays asserted.
- Latency:
  - The last word accepted at edge N gives block_valid_o=1 after edge N.
  - The block handshake at edge M gives word_ready_o=1 after edge M. There is one bubble cycle between blocks by design; no word is accepted in a HOLD cycle even if word_valid_i=1.
- block_ready_i asserted during FILL: ignored.
- word_valid_i asserted during HOLD: ignored. Upstream must hold the word until word_ready_o=1.
- All outputs are registered except word_ready_o and block_valid_o, which are decoded from state only (no combinational path from inputs).

Optional Feature:
- Macro: INPUT_WORD_PACKER_ZERO_PAD_EN.
- Defined:
  - Accepting a word with word_last_i=1 in FILL moves to HOLD regardless of idx.
  - Unwritten slots remain 0, since they were cleared at the previous handshake or at reset.
  - block_words_o reports the actual count, e.g. 3.
  - word_last_i on slot 15 behaves identically to a normal completion.
- Not defined:
  - word_last_i is ignored.
  - HOLD is entered only after 16 words.
  - block_words_o reads 16 whenever block_valid_o=1.

Test Plan:
- Reset, then 16 back-to-back words with data = 64'h1000_0000_0000_0000+k for k=0..15 -> block_valid_o=1 one cycle after the 16th accept; block_o[63:0]=64'h1000_0000_0000_0000, block_o[1023:960]=64'h1000_0000_0000_000F; block_words_o=16.
- Hold block_ready_i=0 for 5 cycles with word_valid_i=1 and data 64'hDEAD -> word_ready_o=0 throughout and block_o unchanged. Then pulse block_ready_i -> block_o=0 and word_ready_o=1 on the next cycle; the first new word lands in [63:0].
- Random word_valid_i gaps (50% duty) over 16 words -> block_o is identical to the gap-free case; no slot is skipped or duplicated.
- Assert rst_n_i=0 after 7 words accepted -> next cycle block_o=0, block_words_o=0, state FILL. The next 16 words form a clean block.
- ZERO_PAD_EN defined: 3 words AA, BB, CC, with word_last_i on CC -> block_valid_o=1, block_o[191:0]={CC,BB,AA}, bits [1023:192]=0, block_words_o=3.
- ZERO_PAD_EN undefined: same stimulus -> block_valid_o stays 0 and block_words_o=3 until 13 more words arrive.
